jam_cost_table: RTL and testbench
=================================

Name: jam_cost_table

Overview:
- Responder side of the job-assignment cost lookup interface: holds the 8x8 worker/job cost matrix and returns Cost for the (W, J) address presented by the assignment engine.
- Loaded once per problem from a host stream (valid/ready, row-major), then serves lookups with zero-cycle combinational read.
- Captures the engine's final result (MatchCount, MinCost) on Valid and presents it to the host, then accepts a reload for the next problem.

Parameters:
- N_IDX, 8, workers and jobs per side; matrix is N_IDX*N_IDX entries.
- COST_W, 7, width of one cost entry.
- CNT_W, 16, width of the lookup counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- load_valid  in  1  host cost word valid.
- load_data  in  COST_W  cost word; order is row-major, index = W*8+J.
- load_last  in  1  marks entry 63.
- load_ready  out  1  table accepts a word this cycle.
- W  in  3  worker address from engine.
- J  in  3  job address from engine.
- Cost  out  COST_W  table[W*8+J].
- table_ready  out  1  full matrix loaded; lookups valid.
- Valid  in  1  engine done strobe (level; first rising edge counts).
- MatchCount  in  4  engine result.
- MinCost  in  10  engine result.
- result_valid  out  1  result registers hold a captured result.
- result_match  out  4  captured MatchCount.
- result_cost  out  10  captured MinCost.
- lookup_cnt  out  CNT_W  lookups served in current problem.
- load_err  out  1  sticky framing error on last load.

Behaviour:
- Reset values:
  - state = LOAD; load_ptr = 0; load_ready = 1.
  - table_ready = 0; result_valid = 0; result_match = 0; result_cost = 0.
  - lookup_cnt = 0; load_err = 0; Valid_d = 0; addr_d = 0.
  - Table contents are not reset.
- States: LOAD, SERVE, DONE.
- LOAD:
  - load_ready = 1.
  - A word is accepted when load_valid & load_ready: table[load_ptr] <= load_data; load_ptr increments (6 bit).
  - Accepted word with load_ptr == 63 and load_last = 1: table_ready <= 1, load_ptr <= 0, load_err <= 0, go SERVE.
  - Framing error, either:
    - load_last = 1 with load_ptr != 63, or
    - load_ptr == 63 with load_last = 0.
  - On error: load_err <= 1, load_ptr <= 0, stay LOAD. The partially written table is discarded logically and table_ready stays 0.
- SERVE:
  - load_ready = 0.
  - Cost = table[{W,J}] combinationally; no register stage. The engine samples on the falling edge, so the read path must settle within half a cycle.
  - addr_d registers {W,J} every cycle. lookup_cnt increments when {W,J} != addr_d; it saturates at all-ones.
  - Valid_d registers Valid. On Valid & ~Valid_d:
    - result_match <= MatchCount; result_cost <= MinCost.
    - result_valid <= 1; go DONE.
- DONE:
  - Cost is still served from the table; lookup_cnt is frozen.
  - load_ready = 1. The first accepted load word:
    - clears table_ready, result_valid and lookup_cnt;
    - writes table[0]; sets load_ptr = 1; goes LOAD.
- Cost when table_ready = 0: drive 0.
- Simultaneous events:
  - Valid rising in the same cycle as a load word is impossible, because load_ready = 0 in SERVE.
  - Valid held high across DONE->LOAD->SERVE is not recaptured until it drops and rises again (edge detect via Valid_d, updated in all states).
- Reset mid-load or mid-serve: immediate return to reset values. The host must reload all 64 words.
- Widths: load_ptr 6 bit wraps only through the handled 63 case; result fields are copied unmodified.

Decomposition:
- Shared package jam_pkg:
  - constants N_IDX=8, COST_W=7, MINCOST_W=10, MATCH_W=4;
  - state enum {LOAD, SERVE, DONE};
  - address typedef {w[2:0], j[2:0]}.
- One sub-module, jam_cost_mem: 64 x COST_W storage with one synchronous write port and one asynchronous read port. It is kept separate so it can be swapped for a macro. FSM, counters and result capture stay in the top module.

Test Plan:
- Load table[i] = i mod 100 for i = 0..63 with load_last on the 64th word -> table_ready = 1 one cycle later. W=3, J=5 -> Cost = 29 combinationally; W=7, J=7 -> Cost = 63.
- Stall the host with load_valid low for 5 cycles mid-stream -> load_ptr holds and the final table is identical to the back-to-back load.
- load_last on the 10th word -> load_err = 1, table_ready = 0, Cost = 0. A subsequent correct 64-word load -> load_err = 0, table_ready = 1.
- In SERVE, sweep W=0..7 with J fixed, then repeat the last address for 3 cycles -> lookup_cnt = 8 (first change from addr_d = 0 counts only if the address differs).
- Valid rises with MatchCount=3, MinCost=10'd412 -> next cycle result_valid = 1, result_match = 3, result_cost = 412, state DONE. Valid held high 4 more cycles -> no recapture.
- Assert RST for 1 cycle at load word 30 -> all outputs at reset values. A full reload then serves correct Cost values.

Source files
------------

// File: rtl/jam_pkg.sv
// ==== jam_pkg : shared constants and types for the job-assignment cost table ====
// ==== rev 1.0                                                                 ====
`default_nettype none

package jam_pkg;

  localparam int N_IDX     = 8;
  localparam int COST_W    = 7;
  localparam int MINCOST_W = 10;
  localparam int MATCH_W   = 4;
  localparam int ADDR_W    = 6;

  // Legacy-compatible state encoding: LOAD, SERVE, DONE
  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef struct packed {
    logic [2:0] w;
    logic [2:0] j;
  } jam_addr_t;

endpackage

`default_nettype wire

// File: rtl/jam_cost_table_if.sv
// ==== jam_cost_table_if : host load stream, engine lookup and result bus ====
// ==== rev 1.0                                                            ====
`default_nettype none

interface jam_cost_table_if import jam_pkg::*; #(
  parameter int COST_W = jam_pkg::COST_W,
  parameter int CNT_W  = 16
);

  logic                 load_valid;
  logic [COST_W-1:0]    load_data;
  logic                 load_last;
  logic                 load_ready;
  logic [2:0]           W;
  logic [2:0]           J;
  logic [COST_W-1:0]    Cost;
  logic                 table_ready;
  logic                 Valid;
  logic [MATCH_W-1:0]   MatchCount;
  logic [MINCOST_W-1:0] MinCost;
  logic                 result_valid;
  logic [MATCH_W-1:0]   result_match;
  logic [MINCOST_W-1:0] result_cost;
  logic [CNT_W-1:0]     lookup_cnt;
  logic                 load_err;

  modport master (
    output load_valid, load_data, load_last, W, J, Valid, MatchCount, MinCost,
    input  load_ready, Cost, table_ready, result_valid, result_match,
           result_cost, lookup_cnt, load_err
  );

  modport slave (
    input  load_valid, load_data, load_last, W, J, Valid, MatchCount, MinCost,
    output load_ready, Cost, table_ready, result_valid, result_match,
           result_cost, lookup_cnt, load_err
  );

endinterface

`default_nettype wire

// File: rtl/jam_cost_mem.sv
// ==== jam_cost_mem : cost storage, one synchronous write, one async read ====
// ==== rev 1.0                                                            ====
`default_nettype none

module jam_cost_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 7,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/jam_cost_table.sv
// ==== jam_cost_table : cost matrix responder with load FSM and result capture ====
// ==== rev 1.0                                                                 ====
`default_nettype none

module jam_cost_table import jam_pkg::*; #(
  parameter int N_IDX  = jam_pkg::N_IDX,
  parameter int COST_W = jam_pkg::COST_W,
  parameter int CNT_W  = 16
) (
  input  logic           CLK,
  input  logic           RST,
  jam_cost_table_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_IDX * N_IDX - 1);

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    load_ptr_q, load_ptr_d;
  logic                 table_ready_q, table_ready_d;
  logic                 result_valid_q, result_valid_d;
  logic [MATCH_W-1:0]   result_match_q, result_match_d;
  logic [MINCOST_W-1:0] result_cost_q, result_cost_d;
  logic [CNT_W-1:0]     lookup_cnt_q, lookup_cnt_d;
  logic                 load_err_q, load_err_d;
  logic                 valid_prev_q, valid_prev_d;
  jam_addr_t            addr_prev_q, addr_prev_d;

  jam_addr_t            addr_now;
  logic                 load_ready;
  logic                 accept;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [COST_W-1:0]    mem_rdata;

  assign addr_now   = {bus.W, bus.J};
  assign load_ready = (state_q != S_SERVE);
  assign accept     = bus.load_valid & load_ready;

  jam_cost_mem #(
    .DEPTH (N_IDX * N_IDX),
    .WIDTH (COST_W),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (bus.load_data),
    .raddr (addr_now),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d        = state_q;
    load_ptr_d     = load_ptr_q;
    table_ready_d  = table_ready_q;
    result_valid_d = result_valid_q;
    result_match_d = result_match_q;
    result_cost_d  = result_cost_q;
    lookup_cnt_d   = lookup_cnt_q;
    load_err_d     = load_err_q;
    valid_prev_d   = bus.Valid;
    addr_prev_d    = addr_now;
    mem_we         = 1'b0;
    mem_waddr      = load_ptr_q;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          mem_we = 1'b1;
          if ((load_ptr_q == LAST_PTR) && bus.load_last) begin
            table_ready_d = 1'b1;
            load_ptr_d    = '0;
            load_err_d    = 1'b0;
            state_d       = S_SERVE;
          end else if (bus.load_last || (load_ptr_q == LAST_PTR)) begin
            // Framing error: restart the frame, whatever was written is ignored
            load_err_d    = 1'b1;
            load_ptr_d    = '0;
            table_ready_d = 1'b0;
          end else begin
            load_ptr_d = load_ptr_q + 1'b1;
          end
        end
      end
      S_SERVE: begin
        if ((addr_now != addr_prev_q) && (lookup_cnt_q != '1)) begin
          lookup_cnt_d = lookup_cnt_q + 1'b1;
        end
        if (bus.Valid && !valid_prev_q) begin
          result_match_d = bus.MatchCount;
          result_cost_d  = bus.MinCost;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        // First word of the next problem always lands in entry 0
        if (accept) begin
          mem_we         = 1'b1;
          mem_waddr      = '0;
          load_ptr_d     = ADDR_W'(1);
          table_ready_d  = 1'b0;
          result_valid_d = 1'b0;
          lookup_cnt_d   = '0;
          state_d        = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= S_LOAD;
      load_ptr_q     <= '0;
      table_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_match_q <= '0;
      result_cost_q  <= '0;
      lookup_cnt_q   <= '0;
      load_err_q     <= 1'b0;
      valid_prev_q   <= 1'b0;
      addr_prev_q    <= '0;
    end else begin
      state_q        <= state_d;
      load_ptr_q     <= load_ptr_d;
      table_ready_q  <= table_ready_d;
      result_valid_q <= result_valid_d;
      result_match_q <= result_match_d;
      result_cost_q  <= result_cost_d;
      lookup_cnt_q   <= lookup_cnt_d;
      load_err_q     <= load_err_d;
      valid_prev_q   <= valid_prev_d;
      addr_prev_q    <= addr_prev_d;
    end
  end

  assign bus.load_ready   = load_ready;
  assign bus.Cost         = table_ready_q ? mem_rdata : '0;
  assign bus.table_ready  = table_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_match = result_match_q;
  assign bus.result_cost  = result_cost_q;
  assign bus.lookup_cnt   = lookup_cnt_q;
  assign bus.load_err     = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_jam_cost_table.sv
// ==== tb_jam_cost_table : scoreboard bench for the cost table responder ====
// ==== rev 1.0                                                           ====
`default_nettype none

module tb_jam_cost_table;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  jam_cost_table_if #(.COST_W(7), .CNT_W(16)) bus ();

  jam_cost_table #(.N_IDX(8), .COST_W(7), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  ref_tbl [64];
  int          exp_q [$];
  string       tag_q [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [6:0] pattern(input int mode, input int i);
    int v;
    v = (mode == 0) ? (i % 100) : ((i * 3 + 7) % 128);
    return 7'(v);
  endfunction

  task automatic load_word(input logic [6:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic load_range(input int mode, input int first, input int stall_at);
    for (int i = first; i < 64; i++) begin
      if (i == stall_at) repeat (5) tick();
      ref_tbl[i] = pattern(mode, i);
      load_word(ref_tbl[i], (i == 63));
    end
  endtask

  // Drive an address, queue the model's cost, compare once the read has settled
  task automatic lookup(input int w, input int j);
    int    e;
    string t;
    bus.W = 3'(w);
    bus.J = 3'(j);
    exp_q.push_back(int'(ref_tbl[w * 8 + j]));
    tag_q.push_back($sformatf("cost_w%0d_j%0d", w, j));
    @(negedge CLK);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val(t, 32'(bus.Cost), 32'(e));
    tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_load_ready"},   32'(bus.load_ready),   32'd1);
    check_val({pfx, "_table_ready"},  32'(bus.table_ready),  32'd0);
    check_val({pfx, "_result_valid"}, 32'(bus.result_valid), 32'd0);
    check_val({pfx, "_result_match"}, 32'(bus.result_match), 32'd0);
    check_val({pfx, "_result_cost"},  32'(bus.result_cost),  32'd0);
    check_val({pfx, "_lookup_cnt"},   32'(bus.lookup_cnt),   32'd0);
    check_val({pfx, "_load_err"},     32'(bus.load_err),     32'd0);
    check_val({pfx, "_cost"},         32'(bus.Cost),         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.W          = '0;
    bus.J          = '0;
    bus.Valid      = 1'b0;
    bus.MatchCount = '0;
    bus.MinCost    = '0;

    #1 RST = 1'b1;
    @(negedge CLK);
    check_reset_vals("rst");
    tick();
    RST = 1'b0;

    // Framing error: load_last on the 10th word
    for (int i = 0; i < 10; i++) begin
      ref_tbl[i] = pattern(0, i);
      load_word(ref_tbl[i], (i == 9));
    end
    bus.W = 3'd0;
    bus.J = 3'd5;
    @(negedge CLK);
    check_val("err_load_err",    32'(bus.load_err),    32'd1);
    check_val("err_table_ready", 32'(bus.table_ready), 32'd0);
    check_val("err_cost",        32'(bus.Cost),        32'd0);
    check_val("err_load_ready",  32'(bus.load_ready),  32'd1);
    bus.W = 3'd0;
    bus.J = 3'd0;
    tick();

    // Back-to-back full load
    load_range(0, 0, -1);
    check_val("load1_table_ready", 32'(bus.table_ready), 32'd1);
    check_val("load1_load_err",    32'(bus.load_err),    32'd0);
    check_val("load1_load_ready",  32'(bus.load_ready),  32'd0);
    check_val("load1_lookup_cnt",  32'(bus.lookup_cnt),  32'd0);

    // Sweep W with J fixed, then hold the last address
    for (int w = 0; w < 8; w++) lookup(w, 5);
    repeat (3) tick();
    @(negedge CLK);
    check_val("sweep_lookup_cnt", 32'(bus.lookup_cnt), 32'd8);
    lookup(7, 7);
    check_val("corner_lookup_cnt", 32'(bus.lookup_cnt), 32'd9);

    // Result capture and no recapture while Valid stays high
    bus.MatchCount = 4'd3;
    bus.MinCost    = 10'd412;
    bus.Valid      = 1'b1;
    tick();
    check_val("cap_result_valid", 32'(bus.result_valid), 32'd1);
    check_val("cap_result_match", 32'(bus.result_match), 32'd3);
    check_val("cap_result_cost",  32'(bus.result_cost),  32'd412);
    check_val("cap_done_ready",   32'(bus.load_ready),   32'd1);
    bus.MatchCount = 4'd5;
    bus.MinCost    = 10'd100;
    lookup(2, 1);
    repeat (3) tick();
    check_val("hold_result_match", 32'(bus.result_match), 32'd3);
    check_val("hold_result_cost",  32'(bus.result_cost),  32'd412);
    check_val("hold_lookup_cnt",   32'(bus.lookup_cnt),   32'd9);

    // Reload from DONE with a mid-stream stall, Valid still held high
    ref_tbl[0] = pattern(0, 0);
    load_word(ref_tbl[0], 1'b0);
    check_val("reload_result_valid", 32'(bus.result_valid), 32'd0);
    check_val("reload_table_ready",  32'(bus.table_ready),  32'd0);
    check_val("reload_lookup_cnt",   32'(bus.lookup_cnt),   32'd0);
    load_range(0, 1, 20);
    check_val("stall_table_ready",  32'(bus.table_ready),  32'd1);
    check_val("stall_load_ready",   32'(bus.load_ready),   32'd0);
    check_val("stall_no_recapture", 32'(bus.result_valid), 32'd0);
    for (int a = 0; a < 64; a++) lookup(a / 8, a % 8);
    check_val("full_lookup_cnt", 32'(bus.lookup_cnt), 32'd64);
    bus.Valid = 1'b0;
    tick();
    bus.MatchCount = 4'd9;
    bus.MinCost    = 10'd1023;
    bus.Valid      = 1'b1;
    tick();
    bus.Valid = 1'b0;
    check_val("cap2_result_valid", 32'(bus.result_valid), 32'd1);
    check_val("cap2_result_match", 32'(bus.result_match), 32'd9);
    check_val("cap2_result_cost",  32'(bus.result_cost),  32'd1023);

    // Reset asserted while word 30 of the next load is on the bus
    for (int i = 0; i < 30; i++) begin
      ref_tbl[i] = pattern(1, i);
      load_word(ref_tbl[i], 1'b0);
    end
    bus.load_valid = 1'b1;
    bus.load_data  = pattern(1, 30);
    RST = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    RST = 1'b0;
    bus.load_valid = 1'b0;
    tick();
    load_range(1, 0, -1);
    check_val("rl_table_ready", 32'(bus.table_ready), 32'd1);
    for (int a = 0; a < 64; a += 3) lookup(a / 8, a % 8);
    lookup(7, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
